// File: rtl/counter_capture_readout_arb_if.sv
// ---------------------------------------------------------------------------
// counter_capture_readout_arb_if
// Readout handshake bus between the capture arbiter and its downstream sink.
//   o_rd_valid  : readout word valid (arbiter -> sink)
//   i_rd_ready  : sink accepts the word (sink -> arbiter)
//   o_rd_data   : 32-bit captured value
//   o_rd_ch_id  : channel the word came from
//   o_rd_reg_id : capture register index 0..5 (a0,a1,a2,b0,b1,b2)
// Member names are seen from the arbiter side (o_ = arbiter drives).
// ---------------------------------------------------------------------------
interface counter_capture_readout_arb_if #(
  parameter int CH_W = 2
);
  logic            o_rd_valid;
  logic            i_rd_ready;
  logic [31:0]     o_rd_data;
  logic [CH_W-1:0] o_rd_ch_id;
  logic [2:0]      o_rd_reg_id;

  modport master (
    output o_rd_valid, o_rd_data, o_rd_ch_id, o_rd_reg_id,
    input  i_rd_ready
  );

  modport slave (
    input  o_rd_valid, o_rd_data, o_rd_ch_id, o_rd_reg_id,
    output i_rd_ready
  );
endinterface

// File: rtl/counter_capture_readout_arb.sv
// ---------------------------------------------------------------------------
// counter_capture_readout_arb
// Round-robin arbiter that reads out per-channel capture registers.
// Each channel has six status bits {b2,b1,b0,a2,a1,a0}; a set bit means the
// matching 32-bit capture register holds a fresh value. One register is
// served per transaction: IDLE selects, SEND offers the word on the readout
// bus, ACK pulses the read flag, WAIT_CLR waits for the status bit to drop.
// Ports:
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_enable                 : allow new selections in IDLE
//   i_capture_reg_status     : COUNTER_NUM*6 status bits
//   i_capture_data           : COUNTER_NUM*192 capture register contents
//   o_capture_reg_read_flag  : one-cycle acknowledge per status bit
//   o_busy                   : FSM not in IDLE
//   o_timeout_err, i_err_clr : sticky clear-timeout flag and its clear
//   rd_if                    : readout handshake bus (master side)
// ---------------------------------------------------------------------------
module counter_capture_readout_arb #(
  parameter int COUNTER_NUM = 4,
  parameter int CLR_TIMEOUT = 15
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic [COUNTER_NUM*6-1:0]   i_capture_reg_status,
  input  logic [COUNTER_NUM*192-1:0] i_capture_data,
  output logic [COUNTER_NUM*6-1:0]   o_capture_reg_read_flag,
  output logic                       o_busy,
  output logic                       o_timeout_err,
  input  logic                       i_err_clr,
  counter_capture_readout_arb_if.master rd_if
);

  localparam int CH_W  = (COUNTER_NUM > 1) ? $clog2(COUNTER_NUM) : 1;
  localparam int CNT_W = $clog2(CLR_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_ACK, S_WAIT_CLR} state_t;

  state_t                   r_state;
  logic [CH_W-1:0]          r_rr_ptr;
  logic [CH_W-1:0]          r_ch_id;
  logic [2:0]               r_reg_id;
  logic [31:0]              r_rd_data;
  logic                     r_rd_valid;
  logic [COUNTER_NUM*6-1:0] r_read_flag;
  logic                     r_busy;
  logic                     r_timeout_err;
  logic [CNT_W-1:0]         r_clr_cnt;

  logic [5:0]               w_stat [COUNTER_NUM];
  logic [31:0]              w_data [COUNTER_NUM][6];
  logic [COUNTER_NUM*6-1:0] w_flag_onehot;
  logic [CH_W:0]            w_cand;
  logic                     w_req_found;
  logic [CH_W-1:0]          w_sel_ch;
  logic [2:0]               w_sel_reg;
  logic [5:0]               w_sel_field;
  logic                     w_served_bit;
  logic                     w_timeout;
  logic [CH_W-1:0]          w_rr_next;

  // Unpack flat status/data buses and build the one-hot flag for the served bit.
  for (genvar g = 0; g < COUNTER_NUM; g++) begin : g_chan
    assign w_stat[g] = i_capture_reg_status[g*6 +: 6];
    for (genvar r = 0; r < 6; r++) begin : g_reg
      assign w_data[g][r] = i_capture_data[g*192 + r*32 +: 32];
      assign w_flag_onehot[g*6 + r] = (r_ch_id == CH_W'(g)) && (r_reg_id == 3'(r));
    end
  end

  // Round-robin channel search starting at r_rr_ptr, wrapping at COUNTER_NUM-1.
  always_comb begin
    w_req_found = 1'b0;
    w_sel_ch    = '0;
    w_cand      = '0;
    for (int j = 0; j < COUNTER_NUM; j++) begin
      w_cand = {1'b0, r_rr_ptr} + (CH_W+1)'(j);
      if (w_cand >= (CH_W+1)'(COUNTER_NUM)) begin
        w_cand = w_cand - (CH_W+1)'(COUNTER_NUM);
      end else begin
        w_cand = w_cand;
      end
      if (!w_req_found && (w_stat[w_cand[CH_W-1:0]] != 6'd0)) begin
        w_req_found = 1'b1;
        w_sel_ch    = w_cand[CH_W-1:0];
      end else begin
        w_req_found = w_req_found;
      end
    end
  end

  // Lowest set status bit wins inside the chosen channel (a0 first, b2 last).
  always_comb begin
    w_sel_field = w_stat[w_sel_ch];
    w_sel_reg   = 3'd0;
    for (int b = 5; b >= 0; b--) begin
      if (w_sel_field[b]) begin
        w_sel_reg = 3'(b);
      end else begin
        w_sel_reg = w_sel_reg;
      end
    end
  end

  // Served-bit watch, clear-timeout detect and next round-robin pointer.
  always_comb begin
    w_served_bit = w_stat[r_ch_id][r_reg_id];
    // The counter holds 0..CLR_TIMEOUT-1 while waiting; the cycle that would
    // bring it to CLR_TIMEOUT is the last one, giving CLR_TIMEOUT wait cycles.
    w_timeout    = (r_state == S_WAIT_CLR) && w_served_bit &&
                   (r_clr_cnt == CNT_W'(CLR_TIMEOUT - 1));
    if (r_ch_id == CH_W'(COUNTER_NUM - 1)) begin
      w_rr_next = '0;
    end else begin
      w_rr_next = r_ch_id + CH_W'(1);
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_ch_id       <= '0;
      r_reg_id      <= 3'd0;
      r_rd_data     <= 32'd0;
      r_rd_valid    <= 1'b0;
      r_read_flag   <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_clr_cnt     <= '0;
    end else begin
      // A timeout in the same cycle as i_err_clr keeps the flag set.
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (i_err_clr) begin
        r_timeout_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_enable && w_req_found) begin
            r_ch_id    <= w_sel_ch;
            r_reg_id   <= w_sel_reg;
            r_rd_data  <= w_data[w_sel_ch][w_sel_reg];
            r_rd_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (rd_if.i_rd_ready) begin
            r_rd_valid  <= 1'b0;
            r_read_flag <= w_flag_onehot;
            r_state     <= S_ACK;
          end
        end
        S_ACK: begin
          r_read_flag <= '0;
          r_clr_cnt   <= '0;
          r_state     <= S_WAIT_CLR;
        end
        S_WAIT_CLR: begin
          if (!w_served_bit || w_timeout) begin
            r_clr_cnt <= '0;
            r_rr_ptr  <= w_rr_next;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_rd_valid  <= 1'b0;
          r_read_flag <= '0;
          r_busy      <= 1'b0;
          r_clr_cnt   <= '0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_if.o_rd_valid      = r_rd_valid;
  assign rd_if.o_rd_data       = r_rd_data;
  assign rd_if.o_rd_ch_id      = r_ch_id;
  assign rd_if.o_rd_reg_id     = r_reg_id;
  assign o_capture_reg_read_flag = r_read_flag;
  assign o_busy                = r_busy;
  assign o_timeout_err         = r_timeout_err;

endmodule

// File: tb/tb_counter_capture_readout_arb.sv
// ---------------------------------------------------------------------------
// tb_counter_capture_readout_arb
// Directed bench for counter_capture_readout_arb (4 channels, timeout 15):
// a cycle-by-cycle vector table followed by hand-written sequences for
// reset mid-SEND, round-robin fairness and clear timeout.
// ---------------------------------------------------------------------------
module tb_counter_capture_readout_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         err_clr;
  logic [23:0]  status;
  logic [767:0] cdata;
  logic [23:0]  flag;
  logic         busy;
  logic         terr;

  counter_capture_readout_arb_if #(.CH_W(2)) rd_if ();

  counter_capture_readout_arb #(.COUNTER_NUM(4), .CLR_TIMEOUT(15)) dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_enable                (en),
    .i_capture_reg_status    (status),
    .i_capture_data          (cdata),
    .o_capture_reg_read_flag (flag),
    .o_busy                  (busy),
    .o_timeout_err           (terr),
    .i_err_clr               (err_clr),
    .rd_if                   (rd_if)
  );

  always #5 clk = ~clk;

  // Observed outputs packed {valid, ch, reg, data, flag, busy, terr}.
  logic [63:0] obs;
  assign obs = {rd_if.o_rd_valid, rd_if.o_rd_ch_id, rd_if.o_rd_reg_id,
                rd_if.o_rd_data, flag, busy, terr};

  typedef struct {
    logic [23:0] st;
    logic        en;
    logic        rdy;
    logic        v;
    logic [1:0]  ch;
    logic [2:0]  rg;
    logic [31:0] d;
    logic [23:0] f;
    logic        b;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] D11 = 32'h1234_5678;
  localparam logic [31:0] D00 = 32'hA500_0000;
  localparam logic [31:0] D22 = 32'hA500_0202;
  localparam logic [31:0] D25 = 32'hA500_0205;
  localparam logic [23:0] ALL_A0 = 24'h041041;

  task automatic add(input logic [23:0] st, input logic e, input logic rdy,
                     input logic v, input logic [1:0] ch, input logic [2:0] rg,
                     input logic [31:0] d, input logic [23:0] f, input logic b);
    vec_t x;
    x.st = st; x.en = e; x.rdy = rdy; x.v = v; x.ch = ch; x.rg = rg;
    x.d = d; x.f = f; x.b = b;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_flag(input int b, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 12 && !ok; c++) begin
      @(negedge clk);
      if ((flag & (24'h1 << b)) != 24'h0) ok = 1'b1;
    end
  endtask

  // Counts negedges with busy=1; returns on the first busy=0 negedge.
  task automatic wait_idle(output int n);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  initial begin
    logic ok;
    int   n;
    int   cd;
    logic [23:0] clrmask;
    int   served[$];
    int   exp_order[5] = '{0, 1, 2, 3, 0};

    rst_n = 1'b0; en = 1'b1; err_clr = 1'b0; status = 24'h0;
    rd_if.i_rd_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 6; k++) begin
        cdata[c*192 + k*32 +: 32] = {8'hA5, 8'h00, 8'(c), 8'(k)};
      end
    end
    cdata[1*192 + 1*32 +: 32] = D11;

    // Single capture ch1/a1 with immediate ready and clear (4-cycle minimum)
    add(24'h0,     1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 24'h0, 1'b0);
    add(24'h80,    1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 32'd0, 24'h0, 1'b0);
    add(24'h80,    1'b1, 1'b1, 1'b1, 2'd1, 3'd1, D11,   24'h0, 1'b1);
    add(24'h0,     1'b1, 1'b1, 1'b0, 2'd1, 3'd1, D11,   24'h80, 1'b1);
    add(24'h0,     1'b1, 1'b1, 1'b0, 2'd1, 3'd1, D11,   24'h0, 1'b1);
    add(24'h0,     1'b1, 1'b1, 1'b0, 2'd1, 3'd1, D11,   24'h0, 1'b0);
    // Backpressure for 10 cycles with status churn on the served channel
    add(24'h80,    1'b1, 1'b0, 1'b0, 2'd1, 3'd1, D11,   24'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      add((i % 2 == 1) ? 24'h1C0 : 24'h80, 1'b1, 1'b0, 1'b1, 2'd1, 3'd1, D11, 24'h0, 1'b1);
    end
    add(24'h80,    1'b1, 1'b1, 1'b1, 2'd1, 3'd1, D11,   24'h0, 1'b1);
    add(24'h0,     1'b1, 1'b1, 1'b0, 2'd1, 3'd1, D11,   24'h80, 1'b1);
    add(24'h0,     1'b1, 1'b1, 1'b0, 2'd1, 3'd1, D11,   24'h0, 1'b1);
    // Intra-channel priority: ch2 a2 before b2
    add(24'h024000, 1'b1, 1'b1, 1'b0, 2'd1, 3'd1, D11,  24'h0, 1'b0);
    add(24'h024000, 1'b1, 1'b1, 1'b1, 2'd2, 3'd2, D22,  24'h0, 1'b1);
    add(24'h020000, 1'b1, 1'b1, 1'b0, 2'd2, 3'd2, D22,  24'h004000, 1'b1);
    add(24'h020000, 1'b1, 1'b1, 1'b0, 2'd2, 3'd2, D22,  24'h0, 1'b1);
    add(24'h020000, 1'b1, 1'b1, 1'b0, 2'd2, 3'd2, D22,  24'h0, 1'b0);
    add(24'h020000, 1'b1, 1'b1, 1'b1, 2'd2, 3'd5, D25,  24'h0, 1'b1);
    add(24'h0,      1'b1, 1'b1, 1'b0, 2'd2, 3'd5, D25,  24'h020000, 1'b1);
    add(24'h0,      1'b1, 1'b1, 1'b0, 2'd2, 3'd5, D25,  24'h0, 1'b1);
    // Enable gates new selections only, not a running transaction
    add(24'h1, 1'b0, 1'b1, 1'b0, 2'd2, 3'd5, D25, 24'h0, 1'b0);
    add(24'h1, 1'b0, 1'b1, 1'b0, 2'd2, 3'd5, D25, 24'h0, 1'b0);
    add(24'h1, 1'b1, 1'b1, 1'b0, 2'd2, 3'd5, D25, 24'h0, 1'b0);
    add(24'h1, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, D00, 24'h0, 1'b1);
    add(24'h0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, D00, 24'h1, 1'b1);
    add(24'h0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, D00, 24'h0, 1'b1);
    add(24'h0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, D00, 24'h0, 1'b0);

    #12;
    check("reset_state", obs, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      status           = vecs[i].st;
      en               = vecs[i].en;
      rd_if.i_rd_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i), obs,
            {vecs[i].v, vecs[i].ch, vecs[i].rg, vecs[i].d, vecs[i].f, vecs[i].b, 1'b0});
    end

    // Reset while SEND is holding a word (pointer is 1 here)
    @(posedge clk); #1;
    en = 1'b1; status = 24'h001000; rd_if.i_rd_ready = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (rd_if.o_rd_valid) ok = 1'b1;
    end
    check("rst_send_reached", 64'(ok), 64'h1);
    check("rst_send_ch", 64'(rd_if.o_rd_ch_id), 64'h2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_send", obs, 64'h0);
    status = ALL_A0; rd_if.i_rd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all channels request a0, each bit dropped 2 cycles after its flag
    cd = 0; clrmask = 24'h0;
    for (int cyc = 0; cyc < 200 && served.size() < 5; cyc++) begin
      @(posedge clk); #1;
      if (cd != 0) begin
        cd--;
        status = (cd == 0) ? (ALL_A0 & ~clrmask) : ALL_A0;
      end else begin
        status = ALL_A0;
      end
      @(negedge clk);
      if (flag != 24'h0) begin
        cd = 2;
        clrmask = flag;
      end
      if (rd_if.o_rd_valid && rd_if.i_rd_ready) served.push_back(int'(rd_if.o_rd_ch_id));
    end
    check("fair_count", 64'(served.size()), 64'd5);
    for (int i = 0; i < served.size() && i < 5; i++) begin
      check($sformatf("fair_order%0d", i), 64'(served[i]), 64'(exp_order[i]));
    end
    @(posedge clk); #1;
    status = 24'h0;
    wait_idle(n);
    check("fair_drain", 64'(busy), 64'h0);

    // Clear timeout: ch3 b2 never clears (pointer is 1 here)
    @(posedge clk); #1;
    status = 24'h800000;
    wait_flag(23, ok);
    check("to_flag", 64'(ok), 64'h1);
    check("to_word", {29'd0, rd_if.o_rd_ch_id, rd_if.o_rd_reg_id, rd_if.o_rd_data},
          {29'd0, 2'd3, 3'd5, 32'hA500_0305});
    wait_idle(n);
    check("to_wait_cycles", 64'(n), 64'd15);
    check("to_err_set", 64'(terr), 64'h1);
    status = 24'h0;
    @(posedge clk); #1;
    @(negedge clk);
    check("to_err_sticky", 64'(terr), 64'h1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("to_err_cleared", 64'(terr), 64'h0);

    // Timeout with i_err_clr held high: set must win
    @(posedge clk); #1;
    status = 24'h800000; err_clr = 1'b1;
    wait_flag(23, ok);
    check("sim_flag", 64'(ok), 64'h1);
    wait_idle(n);
    check("sim_wait_cycles", 64'(n), 64'd15);
    check("sim_set_wins", 64'(terr), 64'h1);
    status = 24'h0;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("sim_clr_after", 64'(terr), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
